// File: rtl/xoodoo_pkg.sv
// Shared constants, types and helpers for the Xoodoo permutation core.
// A 384-bit state maps onto xstate_t so that st[y][x] is lane(x,y).
package xoodoo_pkg;

  localparam int unsigned LANE_W     = 32;
  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned NUM_PLANES = 3;
  localparam int unsigned STATE_W    = LANE_W * NUM_LANES * NUM_PLANES;
  localparam int unsigned MAX_ROUNDS = 12;

  typedef logic [LANE_W-1:0]                                 lane_t;
  typedef logic [NUM_LANES-1:0][LANE_W-1:0]                  plane_t;
  typedef logic [NUM_PLANES-1:0][NUM_LANES-1:0][LANE_W-1:0]  xstate_t;

  localparam lane_t RC [MAX_ROUNDS] = '{
    32'h0000_0058, 32'h0000_0038, 32'h0000_03C0, 32'h0000_00D0,
    32'h0000_0120, 32'h0000_0014, 32'h0000_0060, 32'h0000_002C,
    32'h0000_0380, 32'h0000_00F0, 32'h0000_01A0, 32'h0000_0012
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  function automatic lane_t rotl32(input lane_t v, input int unsigned r);
    return (v << r) | (v >> (LANE_W - r));
  endfunction

  function automatic lane_t get_lane(input xstate_t s, input logic [1:0] x,
                                     input logic [1:0] y);
    return s[y][x];
  endfunction

  function automatic xstate_t set_lane(input xstate_t s, input logic [1:0] x,
                                       input logic [1:0] y, input lane_t v);
    xstate_t r;
    r       = s;
    r[y][x] = v;
    return r;
  endfunction

  // Lane-wise rotation of every lane in a plane.
  function automatic plane_t plane_rotl(input plane_t p, input int unsigned r);
    return {rotl32(p[3], r), rotl32(p[2], r), rotl32(p[1], r), rotl32(p[0], r)};
  endfunction

  // Result lane x takes input lane (x - n) mod 4.
  function automatic plane_t plane_shift(input plane_t p, input int unsigned n);
    return (p << (LANE_W * n)) | (p >> (LANE_W * (NUM_LANES - n)));
  endfunction

endpackage

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
module xoodoo_round
  import xoodoo_pkg::*;
(
  input  logic [STATE_W-1:0] state_in,
  input  logic [LANE_W-1:0]  rc,
  output logic [STATE_W-1:0] state_out
);

  xstate_t s_in;
  xstate_t s_mid;
  xstate_t s_iota;
  plane_t  p, e;
  plane_t  t0, t1, t2;
  plane_t  w0, w1, w2;
  plane_t  c0, c1, c2;

  assign s_in = xstate_t'(state_in);

  // theta: column parity folded back from the neighbouring column
  assign p  = s_in[0] ^ s_in[1] ^ s_in[2];
  assign e  = plane_rotl(plane_shift(p, 1), 5) ^ plane_rotl(plane_shift(p, 1), 14);
  assign t0 = s_in[0] ^ e;
  assign t1 = s_in[1] ^ e;
  assign t2 = s_in[2] ^ e;

  // rho-west
  assign s_mid = {plane_rotl(t2, 11), plane_shift(t1, 1), t0};

  // iota
  assign s_iota = set_lane(s_mid, 2'd0, 2'd0, get_lane(s_mid, 2'd0, 2'd0) ^ rc);

  assign w0 = s_iota[0];
  assign w1 = s_iota[1];
  assign w2 = s_iota[2];

  // chi
  assign c0 = w0 ^ (~w1 & w2);
  assign c1 = w1 ^ (~w2 & w0);
  assign c2 = w2 ^ (~w0 & w1);

  // rho-east
  assign state_out = {plane_shift(plane_rotl(c2, 8), 2), plane_rotl(c1, 1), c0};

endmodule

// File: rtl/xoodoo_permutation.sv
// Iterative Xoodoo[NUM_ROUNDS] core: one round per clock, start/done handshake
// toward the Xoodyak sponge controller.
module xoodoo_permutation
  import xoodoo_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 12
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] state_out,
  output logic               done,
  output logic               busy,
  output logic [3:0]         round_idx
);

  localparam logic [3:0] FIRST_IDX = 4'(MAX_ROUNDS - NUM_ROUNDS);
  localparam logic [3:0] LAST_IDX  = 4'(MAX_ROUNDS - 1);

  fsm_t               fsm_q, fsm_d;
  logic [STATE_W-1:0] st_q;
  logic [STATE_W-1:0] out_q;
  logic [3:0]         idx_q;
  logic [STATE_W-1:0] round_out;
  lane_t              rc;
  logic               last_round;

  assign rc         = (idx_q < 4'(MAX_ROUNDS)) ? RC[idx_q] : '0;
  assign last_round = (idx_q == LAST_IDX);

  xoodoo_round u_round (
    .state_in  (st_q),
    .rc        (rc),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fsm_q <= IDLE;
    else         fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start) fsm_d = RUN;
      RUN:     if (last_round) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // busy/done decode straight from the state register, so both are glitch-free
  // registered outputs that track the RUN and DONE cycles exactly.
  always_comb begin
    busy = (fsm_q == RUN);
    done = (fsm_q == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q  <= '0;
      out_q <= '0;
      idx_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (start) begin
          st_q  <= state_in;
          idx_q <= FIRST_IDX;
        end
        RUN: begin
          st_q  <= round_out;
          idx_q <= idx_q + 4'd1;
          if (last_round) out_q <= round_out;
        end
        default: ;
      endcase
    end
  end

  assign state_out = out_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_xoodoo_permutation.sv
// Directed + random checks of xoodoo_permutation against a lane-array model.
module tb_xoodoo_permutation;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start12, start1;
  logic [383:0] in12, in1;
  logic [383:0] out12, out1;
  logic         done12, done1, busy12, busy1;
  logic [3:0]   idx12, idx1;

  int vectors = 0;
  int miscompares = 0;

  bit [31:0] rc_tab [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                             32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

  always #5 clk = ~clk;

  xoodoo_permutation #(.NUM_ROUNDS(12)) dut12 (
    .clk(clk), .resetn(resetn), .start(start12), .state_in(in12),
    .state_out(out12), .done(done12), .busy(busy12), .round_idx(idx12));

  xoodoo_permutation #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .state_in(in1),
    .state_out(out1), .done(done1), .busy(busy1), .round_idx(idx1));

  function automatic bit [31:0] rol(input bit [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [383:0] ref_perm(input logic [383:0] s, input int nr);
    bit [31:0] a [3][4];
    bit [31:0] b [3][4];
    bit [31:0] p [4];
    bit [31:0] e [4];
    bit [31:0] t [4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = s[32*(x+4*y) +: 32];
    for (int rd = 12 - nr; rd < 12; rd++) begin
      for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int x = 0; x < 4; x++) e[x] = rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] ^= e[x];
      t = a[1];
      for (int x = 0; x < 4; x++) begin
        a[1][x] = t[(x+3)%4];
        a[2][x] = rol(a[2][x], 11);
      end
      a[0][0] ^= rc_tab[rd];
      for (int x = 0; x < 4; x++) begin
        b[0][x] = ~a[1][x] & a[2][x];
        b[1][x] = ~a[2][x] & a[0][x];
        b[2][x] = ~a[0][x] & a[1][x];
      end
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] ^= b[y][x];
      t = a[2];
      for (int x = 0; x < 4; x++) begin
        a[1][x] = rol(a[1][x], 1);
        a[2][x] = rol(t[(x+2)%4], 8);
      end
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) r[32*(x+4*y) +: 32] = a[y][x];
    return r;
  endfunction

  function automatic logic [383:0] rand_state();
    logic [383:0] s;
    for (int i = 0; i < 12; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; pulses start for one cycle and waits (bounded) for done.
  task automatic perm12(input logic [383:0] s, input logic [383:0] hold, input bit chk_hold,
                        output int lat, output int busy_cyc, output bit hold_ok,
                        output logic [383:0] res);
    in12 = s; start12 = 1'b1;
    lat = 0; busy_cyc = 0; hold_ok = 1'b1;
    do begin
      @(negedge clk);
      start12 = 1'b0;
      in12 = rand_state();
      lat++;
      if (busy12) busy_cyc++;
      if (chk_hold && !done12 && out12 !== hold) hold_ok = 1'b0;
    end while (!done12 && lat < 40);
    res = out12;
  endtask

  initial begin
    logic [383:0] s, exp, res, prev;
    int lat, bc, extra;
    bit hok;

    resetn = 1'b0; start12 = 1'b0; start1 = 1'b0; in12 = '0; in1 = '0;
    #12;
    chk("reset_out12", out12, '0);
    chk("reset_ctl12", {done12, busy12, idx12}, '0);
    chk("reset_out1", out1, '0);
    chk("reset_ctl1", {done1, busy1, idx1}, '0);
    @(negedge clk); resetn = 1'b1;

    // NUM_ROUNDS=1 on the zero state
    @(negedge clk);
    in1 = '0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; lat = 1;
    chk("n1_round_idx", 384'(idx1), 384'(4'd11));
    while (!done1 && lat < 40) begin @(negedge clk); lat++; end
    chk("n1_latency", 384'(lat), 384'(2));
    exp = '0; exp[31:0] = 32'h0000_0012; exp[159:128] = 32'h0000_0024;
    chk("n1_zero_const", out1, exp);
    chk("n1_zero_model", out1, ref_perm('0, 1));
    @(negedge clk);
    chk("n1_done_width", 384'(done1), 384'(0));

    // NUM_ROUNDS=12 on the zero state
    perm12('0, '0, 1'b0, lat, bc, hok, res);
    chk("n12_latency", 384'(lat), 384'(13));
    chk("n12_busy_cycles", 384'(bc), 384'(12));
    chk("n12_zero_model", res, ref_perm('0, 12));
    prev = res;

    // 200 random states back-to-back, start the cycle after each done
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("rand_done_width", 384'(done12), 384'(0));
      s = rand_state();
      perm12(s, prev, 1'b1, lat, bc, hok, res);
      chk("rand_latency", 384'(lat), 384'(13));
      chk("rand_hold", 384'(hok), 384'(1));
      chk("rand_result", res, ref_perm(s, 12));
      prev = res;
    end

    // start re-pulsed mid-run with a different state is ignored
    @(negedge clk);
    s = rand_state();
    in12 = s; start12 = 1'b1;
    @(negedge clk); start12 = 1'b0; lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    in12 = rand_state(); start12 = 1'b1;
    @(negedge clk); start12 = 1'b0; lat++;
    while (!done12 && lat < 40) begin @(negedge clk); lat++; end
    res = out12;
    chk("repulse_latency", 384'(lat), 384'(13));
    chk("repulse_result", res, ref_perm(s, 12));
    extra = 0;
    repeat (16) begin @(negedge clk); if (done12) extra++; end
    chk("repulse_single_done", 384'(extra), 384'(0));

    // asynchronous reset between edges mid-run
    in12 = rand_state(); start12 = 1'b1;
    @(negedge clk); start12 = 1'b0;
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_out", out12, '0);
    chk("async_rst_ctl", {done12, busy12, idx12}, '0);
    extra = 0;
    repeat (15) begin @(negedge clk); if (done12) extra++; end
    chk("async_rst_no_done", 384'(extra), 384'(0));
    resetn = 1'b1;
    @(negedge clk);
    s = rand_state();
    perm12(s, '0, 1'b1, lat, bc, hok, res);
    chk("post_rst_latency", 384'(lat), 384'(13));
    chk("post_rst_result", res, ref_perm(s, 12));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xoodoo_permutation.md
Name: xoodoo_permutation

Overview:
- Iterative Xoodoo[NUM_ROUNDS] permutation core on a 384-bit state, computing one round per clock.
- Sits directly downstream of the Xoodyak sponge controller:
  - consumes the controller's `xoodoo_enable` pulse and `state_out` bus;
  - returns the permuted state plus a one-cycle completion pulse, which drive the controller's `state_in` and `xoodoo_complete`.
- Replaces the testbench behavioural model of the permutation.

Parameters:
- NUM_ROUNDS, 12, rounds applied; legal 1..12; applies the last NUM_ROUNDS constants of the 12-entry table.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  reset; one clock; asynchronous, active-low
- start  input  1  one-cycle request pulse, driven by controller `xoodoo_enable`
- state_in  input  384  state to permute, driven by controller `state_out`; sampled only on an accepted start
- state_out  output  384  permuted state, driven to controller `state_in`
- done  output  1  one-cycle completion pulse, driven to controller `xoodoo_complete`
- busy  output  1  high while rounds are in progress
- round_idx  output  4  current round-constant index (debug)

Behaviour:
- Lane mapping: lane(x,y) = state[32*(x+4y) +: 32], x in 0..3, y in 0..2. Plane 0 = bits 127:0, which is the controller's absorb block. Bytes within a lane are little-endian.
- Reset (async, resetn=0): state register = 0, state_out = 0, done = 0, busy = 0, round_idx = 0, FSM = IDLE. Reset mid-run aborts with no done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> load state register from state_in, round_idx <= 12-NUM_ROUNDS, busy <= 1, go to RUN.
  - start=0 -> stay in IDLE.
- RUN, each cycle:
  - state <= round(state, RC[round_idx]); round_idx++.
  - When round_idx == 11 is applied -> go to DONE, busy <= 0, done <= 1, state_out <= result.
- DONE (one cycle): done <= 0, return to IDLE. state_out holds its value until the next completion.
- Latency: with start high in cycle T, done is high in cycle T+NUM_ROUNDS+1 (T+13 at the default). This is within the controller's 18-cycle xoodoo window.
- done is registered and lasts exactly one cycle; state_out is valid in the same cycle as done.
- start while busy or in DONE: ignored. No queueing, no state change.
- start in the same cycle as done: ignored. The controller never does this.
- Round function, with all rotations left-cyclic on 32 bits and lane index x taken mod 4:
  - theta: P[x] = A0[x]^A1[x]^A2[x]; E[x] = (P[x-1]<<<5) ^ (P[x-1]<<<14); Ay[x] ^= E[x].
  - rho-west: A1[x] <= A1[x-1]; A2[x] <= A2[x]<<<11.
  - iota: A0[0] ^= RC (zero-extended to 32 bits).
  - chi: B0 = ~A1&A2, B1 = ~A2&A0, B2 = ~A0&A1; Ay ^= By.
  - rho-east: A1[x] <<<= 1; A2[x] <= A2[x+2]<<<8.
- RC table, index 0..11: 058, 038, 3C0, 0D0, 120, 014, 060, 02C, 380, 0F0, 1A0, 012 (hex).

Decomposition:
- Package xoodoo_pkg:
  - RC table as a 12x32 constant array;
  - lane width, plane and lane count constants;
  - lane get/set functions;
  - rotl32 function;
  - FSM state enum.
- Sub-module xoodoo_round: purely combinational; inputs 384-bit state and 32-bit rc, output 384-bit state. Instanced once. Reused later for an unrolled variant.

Test Plan:
- NUM_ROUNDS=1, state_in=0, single start:
  - done exactly 2 cycles after start;
  - state_out[31:0]=32'h00000012, state_out[159:128]=32'h00000024, all other bits 0.
- NUM_ROUNDS=12, state_in=0:
  - done at start+13;
  - state_out matches the C reference Xoodoo permutation, 384 bits bit-exact;
  - busy high for exactly 12 cycles.
- 200 random states back-to-back, each start issued the cycle after done:
  - all match the reference model;
  - done exactly one cycle wide;
  - state_out stable between dones.
- start re-pulsed during RUN (round 5) with a different state_in:
  - ignored; result equals the original input's permutation;
  - single done at start+13.
- resetn dropped asynchronously mid-RUN (between edges):
  - outputs go to 0 immediately, no done;
  - a fresh start after release completes normally.
- Integrated with the Xoodyak controller, msg_len=16, bytes 00..0F:
  - xoodoo_complete lands inside the ABSORB_XOODOO window;
  - the controller's state register captures state_out;
  - the FSM reaches SQUEEZE.
